// File: rtl/hd63701_seq_pkg.sv
// Shared phase codes, vector encodings and step-toggle type for the HD63701 phase sequencer.
package hd63701_seq_pkg;

  localparam logic [5:0] PH_RST       = 6'd0;
  localparam logic [5:0] PH_VECT      = 6'd1;
  localparam logic [5:0] PH_VEC1      = 6'd2;
  localparam logic [5:0] PH_VEC2      = 6'd3;
  localparam logic [5:0] PH_FETCH     = 6'd4;
  localparam logic [5:0] PH_EXEC      = 6'd16;
  localparam logic [5:0] PH_INTR      = 6'd32;
  localparam logic [5:0] PH_INTR_LAST = 6'd39;
  localparam logic [5:0] PH_SLEEP     = 6'd48;
  localparam logic [5:0] PH_HALT      = 6'd63;

  localparam logic [1:0] VS_RST  = 2'd0;
  localparam logic [1:0] VS_NMI  = 2'd1;
  localparam logic [1:0] VS_IRQ  = 2'd2;
  localparam logic [1:0] VS_TRAP = 2'd3;

  typedef enum logic {STEP_ISSUE, STEP_EXEC} step_t;

endpackage

// File: rtl/hd63701_seq_irq.sv
// NMI latch, interrupt-pending detection and vector priority (TRAP > NMI > IRQ).
module hd63701_seq_irq
  import hd63701_seq_pkg::*;
#(
  parameter bit NMI_EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nmi,
  input  logic       irq,
  input  logic       imask,
  input  logic       take,
  input  logic       trap_set,
  output logic       pending,
  output logic [1:0] vsel_next
);

  logic nmi_prev;
  logic nmi_latch;
  logic trap_flag;
  logic nmi_set;

  assign nmi_set = NMI_EDGE ? (nmi & ~nmi_prev) : nmi;
  assign pending = nmi_latch | (irq & ~imask);

  always_comb begin
    vsel_next = VS_IRQ;
    if (trap_flag)
      vsel_next = VS_TRAP;
    else if (nmi_latch)
      vsel_next = VS_NMI;
  end

  // A fresh NMI arriving in the same cycle as the vector load must survive the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nmi_prev  <= 1'b0;
      nmi_latch <= 1'b0;
      trap_flag <= 1'b0;
    end else begin
      nmi_prev <= nmi;
      if (nmi_set)
        nmi_latch <= 1'b1;
      else if (take && vsel_next == VS_NMI)
        nmi_latch <= 1'b0;
      if (trap_set)
        trap_flag <= 1'b1;
      else if (take)
        trap_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/hd63701_seq.sv
// HD63701 phase sequencer: two-clock microsteps driving PHASE/OPCODE to the microcode ROM.
// Optional feature macro HD63701_TRAP_EN: EXEC overrun traps through INTR (VSEL=3) instead of halting.
module hd63701_seq
  import hd63701_seq_pkg::*;
#(
  parameter int MAXSTEP  = 10,
  parameter bit NMI_EDGE = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RDY,
  input  logic [7:0] DIN,
  input  logic       MC_END,
  input  logic       MC_SLP,
  input  logic       NMI,
  input  logic       IRQ,
  input  logic       IMASK,
  output logic [5:0] PHASE,
  output logic [7:0] OPCODE,
  output logic       MC_VALID,
  output logic       FETCH,
  output logic [1:0] VSEL,
  output logic       HALTED
);

  localparam logic [5:0] PH_EXEC_LAST = PH_EXEC + 6'(MAXSTEP - 1);

  step_t      step;
  logic [5:0] next_phase;
  logic       in_exec;
  logic       in_intr;
  logic       advance;
  logic       take;
  logic       trap_set;
  logic       pending;
  logic [1:0] vsel_next;

  assign in_exec = (PHASE >= PH_EXEC) && (PHASE <= PH_EXEC_LAST);
  assign in_intr = (PHASE >= PH_INTR) && (PHASE <= PH_INTR_LAST);
  assign advance = (step == STEP_EXEC) && RDY;
  assign take    = advance && (PHASE == PH_INTR_LAST);

`ifdef HD63701_TRAP_EN
  assign trap_set = advance && (PHASE == PH_EXEC_LAST) && !MC_SLP && !MC_END;
`else
  assign trap_set = 1'b0;
`endif

  hd63701_seq_irq #(.NMI_EDGE(NMI_EDGE)) u_irq (
    .clk       (CLK),
    .rst_n     (RST_N),
    .nmi       (NMI),
    .irq       (IRQ),
    .imask     (IMASK),
    .take      (take),
    .trap_set  (trap_set),
    .pending   (pending),
    .vsel_next (vsel_next)
  );

  // Phase to load at the end of an EXEC cycle; SLP outranks END.
  always_comb begin
    next_phase = PH_HALT;
    if (PHASE == PH_RST)
      next_phase = PH_VECT;
    else if (PHASE == PH_VECT)
      next_phase = PH_VEC1;
    else if (PHASE == PH_VEC1)
      next_phase = PH_VEC2;
    else if (PHASE == PH_VEC2)
      next_phase = PH_FETCH;
    else if (PHASE == PH_FETCH)
      next_phase = PH_EXEC;
    else if (in_exec) begin
      if (MC_SLP)
        next_phase = PH_SLEEP;
      else if (MC_END)
        next_phase = pending ? PH_INTR : PH_FETCH;
      else if (PHASE == PH_EXEC_LAST) begin
`ifdef HD63701_TRAP_EN
        next_phase = PH_INTR;
`else
        next_phase = PH_HALT;
`endif
      end else
        next_phase = PHASE + 6'd1;
    end else if (in_intr)
      next_phase = (PHASE == PH_INTR_LAST) ? PH_VECT : PHASE + 6'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PHASE    <= PH_RST;
      OPCODE   <= 8'h00;
      MC_VALID <= 1'b0;
      FETCH    <= 1'b0;
      VSEL     <= VS_RST;
      HALTED   <= 1'b0;
      step     <= STEP_ISSUE;
    end else if (PHASE == PH_SLEEP) begin
      MC_VALID <= 1'b0;
      step     <= STEP_ISSUE;
      if (pending)
        PHASE <= PH_INTR;
    end else if (PHASE == PH_HALT) begin
      MC_VALID <= 1'b0;
      HALTED   <= 1'b1;
    end else if (step == STEP_ISSUE) begin
      step     <= STEP_EXEC;
      MC_VALID <= 1'b1;
    end else if (advance) begin
      PHASE    <= next_phase;
      step     <= STEP_ISSUE;
      MC_VALID <= 1'b0;
      FETCH    <= (next_phase == PH_FETCH);
      HALTED   <= (next_phase == PH_HALT);
      if (PHASE == PH_FETCH)
        OPCODE <= DIN;
      if (take)
        VSEL <= vsel_next;
    end
  end

endmodule

// File: tb/tb_hd63701_seq.sv
// Directed self-checking bench for hd63701_seq: vector table plus hand-written interrupt/sleep/halt sequences.
module tb_hd63701_seq;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       RDY = 1'b1;
  logic [7:0] DIN = 8'h00;
  logic       MC_END = 1'b0;
  logic       MC_SLP = 1'b0;
  logic       NMI = 1'b0;
  logic       IRQ = 1'b0;
  logic       IMASK = 1'b0;
  logic [5:0] PHASE;
  logic [7:0] OPCODE;
  logic       MC_VALID;
  logic       FETCH;
  logic [1:0] VSEL;
  logic       HALTED;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       rst_n;
    logic       rdy;
    logic [7:0] din;
    logic       mc_end;
    logic       mc_slp;
    logic [5:0] ph;
    logic [7:0] op;
    logic       valid;
    logic       fetch;
  } vec_t;

  vec_t tbl[22];

  hd63701_seq dut (
    .CLK(CLK), .RST_N(RST_N), .RDY(RDY), .DIN(DIN), .MC_END(MC_END), .MC_SLP(MC_SLP),
    .NMI(NMI), .IRQ(IRQ), .IMASK(IMASK), .PHASE(PHASE), .OPCODE(OPCODE),
    .MC_VALID(MC_VALID), .FETCH(FETCH), .VSEL(VSEL), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One full microstep from the ISSUE cycle, with flags presented for the EXEC cycle.
  task automatic applyStimulus(input logic e, input logic s);
    MC_END = e;
    MC_SLP = s;
    tick();
    tick();
    MC_END = 1'b0;
    MC_SLP = 1'b0;
  endtask

  task automatic stepExpect(input string nm, input logic e, input logic s, input int ph);
    applyStimulus(e, s);
    checkOutput(nm, int'(PHASE), ph);
  endtask

  task automatic intrToVect(input string nm, input int vs);
    for (int k = 1; k < 8; k++)
      stepExpect("intr_seq", 1'b0, 1'b0, 32 + k);
    stepExpect("intr7_to_vect", 1'b0, 1'b0, 1);
    checkOutput(nm, int'(VSEL), vs);
  endtask

  task automatic vectToExec(input logic [7:0] op);
    DIN = op;
    stepExpect("vect_vec1", 1'b0, 1'b0, 2);
    stepExpect("vec1_vec2", 1'b0, 1'b0, 3);
    stepExpect("vec2_fetch", 1'b0, 1'b0, 4);
    stepExpect("fetch_exec", 1'b0, 1'b0, 16);
    checkOutput("opcode_latch", int'(OPCODE), int'(op));
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 6'd0,  8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd1,  8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd1,  8'h00, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd2,  8'h00, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd2,  8'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd3,  8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd3,  8'h00, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd4,  8'h00, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 6'd4,  8'h00, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 8'h86, 1'b0, 1'b0, 6'd16, 8'h86, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'h86, 1'b0, 1'b0, 6'd16, 8'h86, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'h86, 1'b0, 1'b0, 6'd17, 8'h86, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 8'h86, 1'b0, 1'b0, 6'd17, 8'h86, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'h86, 1'b0, 1'b0, 6'd17, 8'h86, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'h86, 1'b0, 1'b0, 6'd17, 8'h86, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 8'h86, 1'b0, 1'b0, 6'd17, 8'h86, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 8'h86, 1'b0, 1'b0, 6'd18, 8'h86, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 8'h86, 1'b0, 1'b0, 6'd18, 8'h86, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 8'h86, 1'b1, 1'b0, 6'd4,  8'h86, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 1'b1, 8'h86, 1'b0, 1'b0, 6'd4,  8'h86, 1'b1, 1'b1};
    tbl[21] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 6'd16, 8'h20, 1'b0, 1'b0};

    // Reset entry, fetch of 0x86, RDY stall in EXEC1, end at EXEC2, refetch.
    for (int i = 0; i < 22; i++) begin
      RST_N  = tbl[i].rst_n;
      RDY    = tbl[i].rdy;
      DIN    = tbl[i].din;
      MC_END = tbl[i].mc_end;
      MC_SLP = tbl[i].mc_slp;
      tick();
      total++;
      if ({PHASE, OPCODE, MC_VALID, FETCH, VSEL, HALTED} !==
          {tbl[i].ph, tbl[i].op, tbl[i].valid, tbl[i].fetch, 2'd0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL vec%0d: got ph=%0d op=%h v=%b f=%b vs=%0d h=%b expected ph=%0d op=%h v=%b f=%b vs=0 h=0",
                 i, PHASE, OPCODE, MC_VALID, FETCH, VSEL, HALTED,
                 tbl[i].ph, tbl[i].op, tbl[i].valid, tbl[i].fetch);
      end
    end
    MC_END = 1'b0;
    RDY = 1'b1;

    // Unmasked IRQ at instruction end.
    IRQ = 1'b1; IMASK = 1'b0;
    stepExpect("irq_end_to_intr", 1'b1, 1'b0, 32);
    intrToVect("irq_vsel", 2);
    IRQ = 1'b0;
    vectToExec(8'h4c);

    // Masked IRQ is ignored.
    IRQ = 1'b1; IMASK = 1'b1;
    stepExpect("masked_irq_fetch", 1'b1, 1'b0, 4);
    IRQ = 1'b0; IMASK = 1'b0;
    stepExpect("masked_fetch_exec", 1'b0, 1'b0, 16);

    // NMI pulse with IRQ: NMI first, then IRQ on the following instruction end.
    NMI = 1'b1; IRQ = 1'b1;
    tick();
    NMI = 1'b0;
    tick();
    checkOutput("nmi_exec0_step", int'(PHASE), 17);
    stepExpect("nmi_end_to_intr", 1'b1, 1'b0, 32);
    intrToVect("nmi_vsel", 1);
    vectToExec(8'h01);
    stepExpect("irq_after_nmi", 1'b1, 1'b0, 32);
    intrToVect("irq_after_nmi_vsel", 2);
    IRQ = 1'b0;
    vectToExec(8'h02);

    // Sleep entered at EXEC1, held with RDY toggling, woken by IRQ.
    stepExpect("sleep_exec1", 1'b0, 1'b0, 17);
    stepExpect("sleep_enter", 1'b0, 1'b1, 48);
    for (int i = 0; i < 20; i++) begin
      RDY = i[0];
      tick();
      checkOutput("sleep_hold_phase", int'(PHASE), 48);
      checkOutput("sleep_valid_low", int'(MC_VALID), 0);
    end
    RDY = 1'b0; IRQ = 1'b1;
    tick();
    checkOutput("sleep_wake_irq", int'(PHASE), 32);
    RDY = 1'b1;
    intrToVect("sleep_irq_vsel", 2);
    IRQ = 1'b0;
    vectToExec(8'h03);

    // SLP and END together: sleep wins; an NMI edge wakes it.
    stepExpect("slp_end_together", 1'b1, 1'b1, 48);
    NMI = 1'b1;
    tick();
    NMI = 1'b0;
    tick();
    checkOutput("sleep_wake_nmi", int'(PHASE), 32);
    intrToVect("sleep_nmi_vsel", 1);
    vectToExec(8'h05);

    // EXEC overrun through EXEC9.
    for (int k = 1; k < 10; k++)
      stepExpect("exec_advance", 1'b0, 1'b0, 16 + k);
`ifdef HD63701_TRAP_EN
    stepExpect("overrun_trap", 1'b0, 1'b0, 32);
    intrToVect("trap_vsel", 3);
    checkOutput("trap_not_halted", int'(HALTED), 0);
`else
    stepExpect("overrun_halt", 1'b0, 1'b0, 63);
    checkOutput("halted_flag", int'(HALTED), 1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("halt_hold", int'(PHASE), 63);
    checkOutput("halt_valid_low", int'(MC_VALID), 0);
`endif

    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    checkOutput("reset_phase", int'(PHASE), 0);
    checkOutput("reset_opcode", int'(OPCODE), 0);
    checkOutput("reset_halted", int'(HALTED), 0);
    checkOutput("reset_vsel", int'(VSEL), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
